// File: rtl/watch_set_ctrl.sv
`default_nettype none
// ============================================================================
// watch_set_ctrl : RUN/SET mode sequencer and stretched pls/clr pulse engine
//                  for the watch sec/min/hr counter chain.
// Revision       : 1.0
// ============================================================================
module watch_set_ctrl #(
    parameter int PW_CYC    = 4,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_clr,
    output logic       sec_pls,
    output logic       min_pls,
    output logic       hr_pls,
    output logic       sec_clr,
    output logic       min_clr,
    output logic       hr_clr,
    output logic       carry_blk,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_HIGH = 2'd1,
        ENG_LOW  = 2'd2
    } eng_state_t;

    localparam logic [1:0] MODE_RUN = 2'd0;
    localparam logic [1:0] MODE_HR  = 2'd1;
    localparam logic [1:0] MODE_MIN = 2'd2;
    localparam logic [1:0] MODE_SEC = 2'd3;
    localparam logic [3:0] PW_LAST  = 4'(PW_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_S - 1);

    logic       btn_mode_q, btn_up_q, btn_clr_q;
    logic       mode_edge, up_edge, clr_edge, any_edge;
    eng_state_t eng_state;
    logic [3:0] eng_cnt;
    logic       eng_is_clr;
    logic       pending;
    logic [5:0] tmo_cnt;

    logic       in_set, eng_free, tick_want;
    logic       req_go, req_clr, tick_take;
    logic [2:0] req_tgt, unit_sel;
    logic [1:0] mode_nxt;

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign up_edge   = btn_up   & ~btn_up_q;
    assign clr_edge  = btn_clr  & ~btn_clr_q;
    assign any_edge  = mode_edge | up_edge | clr_edge;
    assign in_set    = (mode != MODE_RUN);
    assign tick_want = ~in_set & (tick_1hz | pending);

    // Free in the final cycle of a pulse so a queued request follows with no idle gap.
    assign eng_free = (eng_state == ENG_IDLE)
                   || (eng_state == ENG_HIGH && eng_is_clr && eng_cnt == PW_LAST)
                   || (eng_state == ENG_LOW  && eng_cnt == GAP_LAST);

    // Target one-hot {hr,min,sec}; RUN selects all three (used by clear).
    always_comb begin
        case (mode)
            MODE_HR:  unit_sel = 3'b100;
            MODE_MIN: unit_sel = 3'b010;
            MODE_SEC: unit_sel = 3'b001;
            default:  unit_sel = 3'b111;
        endcase
    end

    always_comb begin
        req_go    = 1'b0;
        req_clr   = 1'b0;
        req_tgt   = 3'b000;
        tick_take = 1'b0;
        if (clr_edge) begin
            req_go  = eng_free;
            req_clr = 1'b1;
            req_tgt = unit_sel;
        end else if (up_edge && in_set) begin
            req_go  = eng_free;
            req_tgt = unit_sel;
        end else if (tick_want) begin
            req_go    = eng_free;
            req_tgt   = 3'b001;
            tick_take = eng_free;
        end
    end

    always_comb begin
        mode_nxt = mode;
        if (mode_edge) begin
            mode_nxt = mode + 2'd1;
        end else if (in_set && !any_edge && tick_1hz && tmo_cnt == TMO_LAST) begin
            mode_nxt = MODE_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_mode_q <= 1'b0;
            btn_up_q   <= 1'b0;
            btn_clr_q  <= 1'b0;
            mode       <= MODE_RUN;
            carry_blk  <= 1'b0;
            blink      <= 1'b0;
            tmo_cnt    <= '0;
            pending    <= 1'b0;
            eng_state  <= ENG_IDLE;
            eng_cnt    <= '0;
            eng_is_clr <= 1'b0;
            {hr_pls, min_pls, sec_pls} <= 3'b000;
            {hr_clr, min_clr, sec_clr} <= 3'b000;
        end else begin
            btn_mode_q <= btn_mode;
            btn_up_q   <= btn_up;
            btn_clr_q  <= btn_clr;
            mode       <= mode_nxt;
            carry_blk  <= (mode_nxt != MODE_RUN);

            if (!in_set || mode_nxt != mode || any_edge) begin
                tmo_cnt <= '0;
            end else if (tick_1hz) begin
                tmo_cnt <= tmo_cnt + 6'd1;
            end

            if (!in_set || mode_nxt != mode) begin
                blink <= 1'b0;
            end else if (tick_1hz) begin
                blink <= ~blink;
            end

            if (mode_nxt != MODE_RUN) begin
                pending <= 1'b0;
            end else if (tick_take) begin
                pending <= 1'b0;
            end else if (tick_1hz && !in_set) begin
                pending <= 1'b1;
            end

            case (eng_state)
                ENG_HIGH: begin
                    if (eng_cnt == PW_LAST) begin
                        eng_state <= eng_is_clr ? ENG_IDLE : ENG_LOW;
                        eng_cnt   <= '0;
                        {hr_pls, min_pls, sec_pls} <= 3'b000;
                        {hr_clr, min_clr, sec_clr} <= 3'b000;
                    end else begin
                        eng_cnt <= eng_cnt + 4'd1;
                    end
                end
                ENG_LOW: begin
                    if (eng_cnt == GAP_LAST) begin
                        eng_state <= ENG_IDLE;
                        eng_cnt   <= '0;
                    end else begin
                        eng_cnt <= eng_cnt + 4'd1;
                    end
                end
                default: eng_cnt <= '0;
            endcase

            // An accepted request overrides the phase bookkeeping above.
            if (req_go) begin
                eng_state  <= ENG_HIGH;
                eng_cnt    <= '0;
                eng_is_clr <= req_clr;
                {hr_pls, min_pls, sec_pls} <= req_clr ? 3'b000 : req_tgt;
                {hr_clr, min_clr, sec_clr} <= req_clr ? req_tgt : 3'b000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_watch_set_ctrl.sv
`default_nettype none
// ============================================================================
// tb_watch_set_ctrl : directed scenarios plus randomized buttons/ticks checked
//                     against a cycle-numbered behavioural model.
// Revision          : 1.0
// ============================================================================
module tb_watch_set_ctrl;

    localparam int PW      = 4;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_clr = 1'b0;
    logic       sec_pls, min_pls, hr_pls, sec_clr, min_clr, hr_clr, carry_blk, blink;
    logic [1:0] mode;
    logic [9:0] outs;

    watch_set_ctrl #(.PW_CYC(PW), .GAP_CYC(GAP), .TIMEOUT_S(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_clr(btn_clr),
        .sec_pls(sec_pls), .min_pls(min_pls), .hr_pls(hr_pls),
        .sec_clr(sec_clr), .min_clr(min_clr), .hr_clr(hr_clr),
        .carry_blk(carry_blk), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // {hr_pls,min_pls,sec_pls, hr_clr,min_clr,sec_clr, carry_blk, mode[1:0], blink}
    assign outs = {hr_pls, min_pls, sec_pls, hr_clr, min_clr, sec_clr, carry_blk, mode, blink};

    int n_chk = 0;
    int n_err = 0;
    int c = 0;
    logic [9:0] hist [0:255];
    bit lvl_m, lvl_u, lvl_c;

    // Model state: pulses are kept as absolute cycle windows.
    int m_mode, m_quiet, free_at, hi_from, hi_to;
    bit m_pend, m_blink, p_m, p_u, p_c;
    logic [2:0] hi_pls, hi_clr;

    task automatic chk(input string tag, input int cy, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cy, act, exp);
        end
    endtask

    function automatic logic [2:0] unit_of(input int md);
        case (md)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [9:0] m_out(input int cy);
        logic [2:0] p, k;
        p = (cy >= hi_from && cy <= hi_to) ? hi_pls : 3'b000;
        k = (cy >= hi_from && cy <= hi_to) ? hi_clr : 3'b000;
        return {p, k, (m_mode != 0), 2'(m_mode), m_blink};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_quiet = 0; m_pend = 0; m_blink = 0;
        p_m = 0; p_u = 0; p_c = 0;
        free_at = 0; hi_from = 1; hi_to = 0;
        hi_pls = 3'b000; hi_clr = 3'b000;
    endtask

    task automatic launch(input bit is_clr, input logic [2:0] tgt);
        hi_from = c + 1;
        hi_to   = c + PW;
        hi_pls  = is_clr ? 3'b000 : tgt;
        hi_clr  = is_clr ? tgt : 3'b000;
        free_at = is_clr ? c + PW : c + PW + GAP;
    endtask

    task automatic model_step(input bit t, input bit bm, input bit bu, input bit bc);
        bit em, eu, ec, act, set_now, free, took;
        int nm;
        em = bm && !p_m; eu = bu && !p_u; ec = bc && !p_c;
        p_m = bm; p_u = bu; p_c = bc;
        act = em || eu || ec;
        set_now = (m_mode != 0);
        free = (c >= free_at);
        took = 0;
        if (ec) begin
            if (free) launch(1'b1, unit_of(m_mode));
        end else if (eu && set_now) begin
            if (free) launch(1'b0, unit_of(m_mode));
        end else if (!set_now && (t || m_pend)) begin
            if (free) begin
                launch(1'b0, 3'b001);
                took = 1;
            end
        end
        nm = m_mode;
        if (em) nm = (m_mode + 1) % 4;
        else if (set_now && !act && t && m_quiet + 1 == TIMEOUT) nm = 0;
        if (nm != 0) m_pend = 0;
        else if (took) m_pend = 0;
        else if (t && !set_now) m_pend = 1;
        if (!set_now || nm != m_mode || act) m_quiet = 0;
        else if (t) m_quiet++;
        if (!set_now || nm != m_mode) m_blink = 0;
        else if (t) m_blink = !m_blink;
        m_mode = nm;
    endtask

    // Called at a negedge: check cycle c outputs, drive cycle c inputs, advance.
    task automatic step(input bit t);
        chk("model", c, outs, m_out(c));
        if (c < 256) hist[c] = outs;
        tick_1hz = t; btn_mode = lvl_m; btn_up = lvl_u; btn_clr = lvl_c;
        model_step(t, lvl_m, lvl_u, lvl_c);
        c++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_clr = 0;
        lvl_m = 0; lvl_u = 0; lvl_c = 0;
        repeat (2) begin
            @(negedge clk);
            chk("reset", -1, outs, 10'h000);
        end
        rst = 1'b1;
        c = 0;
        model_reset();
    endtask

    initial begin
        model_reset();

        // Single tick in RUN.
        do_reset();
        for (int k = 0; k < 25; k++) step(k == 10);
        for (int k = 5; k < 25; k++)
            chk("tick_one", k, hist[k], (k >= 11 && k <= 14) ? 10'h080 : 10'h000);

        // Second tick pends, third dropped.
        do_reset();
        for (int k = 0; k < 36; k++) step(k == 10 || k == 12 || k == 13);
        for (int k = 5; k < 36; k++)
            chk("tick_pend", k, hist[k],
                ((k >= 11 && k <= 14) || (k >= 19 && k <= 22)) ? 10'h080 : 10'h000);

        // SET_MIN: up pulses minutes, ticks do not pulse.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            lvl_m = (k == 2 || k == 4); lvl_u = (k == 8); lvl_c = 0;
            step(k == 15 || k == 20 || k == 25);
        end
        for (int k = 6; k < 40; k++) begin
            chk("setmin_mode", k, 10'(hist[k][3:1]), 10'(3'b110));
            chk("setmin_pulse", k, 10'(hist[k][9:4]),
                (k >= 9 && k <= 12) ? 10'(6'b010000) : 10'h000);
        end

        // Clear: all units in RUN, selected unit in SET_HR.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            lvl_c = (k == 5 || k == 15); lvl_m = (k == 12); lvl_u = 0;
            step(1'b0);
        end
        for (int k = 0; k < 30; k++)
            chk("clr", k, 10'(hist[k][9:4]),
                (k >= 6 && k <= 9) ? 10'(6'b000111) :
                (k >= 16 && k <= 19) ? 10'(6'b000100) : 10'h000);
        chk("clr_mode", 20, 10'(hist[20][2:1]), 10'd1);

        // SET_SEC timeout after 30 quiet ticks.
        do_reset();
        for (int k = 0; k < 110; k++) begin
            lvl_m = (k == 2 || k == 4 || k == 6); lvl_u = 0; lvl_c = 0;
            step(k >= 10 && (k - 10) % 3 == 0);
        end
        chk("tmo_set", 96, 10'(hist[96][3:1]), 10'(3'b111));
        chk("tmo_run", 100, 10'(hist[100][3:0]), 10'h000);

        // Up at tick 29 restarts the timeout count.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            lvl_m = (k == 2 || k == 4 || k == 6); lvl_u = (k == 94); lvl_c = 0;
            step(k >= 10 && (k - 10) % 3 == 0 && (k - 10) / 3 < 60);
        end
        chk("tmo_hold", 100, 10'(hist[100][2:1]), 10'd3);
        chk("tmo_hold2", 184, 10'(hist[184][2:1]), 10'd3);
        chk("tmo_rerun", 188, 10'(hist[188][3:0]), 10'h000);

        // SET_MIN: clr and up together -> clr only; then async reset mid-pulse.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            lvl_m = (k == 2 || k == 4); lvl_u = (k == 8 || k == 14); lvl_c = (k == 8);
            step(1'b0);
        end
        for (int k = 0; k < 14; k++)
            chk("clr_vs_up", k, 10'(hist[k][9:4]),
                (k >= 9 && k <= 12) ? 10'(6'b000010) : 10'h000);
        chk("pre_rst", 16, 10'(hist[16][8]), 10'd1);
        #2 rst = 1'b0;
        #1 chk("async_rst", c, outs, 10'h000);

        // Random: busy buttons, then quiet buttons so timeouts occur.
        do_reset();
        lvl_m = 1'($urandom_range(1)); lvl_u = 1'($urandom_range(1)); lvl_c = 1'($urandom_range(1));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(15) == 0) lvl_m = ~lvl_m;
            if ($urandom_range(5) == 0)  lvl_u = ~lvl_u;
            if ($urandom_range(9) == 0)  lvl_c = ~lvl_c;
            step($urandom_range(4) == 0);
        end
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(299) == 0) lvl_m = ~lvl_m;
            if ($urandom_range(199) == 0) lvl_u = ~lvl_u;
            if ($urandom_range(399) == 0) lvl_c = ~lvl_c;
            step($urandom_range(3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
